joybus_tx: RTL



---
 rtl/joybus_tx_pkg.sv | 20 ++
 rtl/joybus_us_tick.sv | 28 ++
 rtl/register_sync.sv | 24 ++
 rtl/joybus_tx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/joybus_tx_pkg.sv
// rtl/joybus_tx_pkg.sv - Joybus timing constants, FSM encoding and frame length helper.
package joybus_tx_pkg;

  localparam int BIT_CELL_US   = 4;
  localparam int BIT1_LOW_US   = 1;
  localparam int BIT0_LOW_US   = 3;
  localparam int MAX_LEN_BYTES = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GUARD    = 3'd1;
  localparam logic [2:0] ST_LOW      = 3'd2;
  localparam logic [2:0] ST_HIGH     = 3'd3;
  localparam logic [2:0] ST_STOP_LOW = 3'd4;
  localparam logic [2:0] ST_STOP_REL = 3'd5;

  function automatic logic [5:0] frame_bits(input logic [2:0] len);
    frame_bits = (len > 3'(MAX_LEN_BYTES)) ? 6'(MAX_LEN_BYTES * 8) : {len, 3'b000};
  endfunction

endpackage

// File: rtl/joybus_us_tick.sv
// rtl/joybus_us_tick.sv - Restartable 1 us prescaler; restart aligns the tick grid to a phase start.
module joybus_us_tick #(
  parameter int CLKS_PER_US = 49
) (
  input  logic clk,
  input  logic nrst,
  input  logic restart,
  output logic us_tick
);

  localparam int            CW     = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_US - 1);

  logic [CW-1:0] cnt;

  assign us_tick = (cnt == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (restart || us_tick) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/register_sync.sv
// rtl/register_sync.sv - Two-flop synchroniser with a configurable reset preset.
module register_sync #(
  parameter int                 WIDTH  = 1,
  parameter logic [WIDTH-1:0]   PRESET = '1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= PRESET;
      q    <= PRESET;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joybus_tx.sv
// rtl/joybus_tx.sv - Joybus open-drain transmitter: guard, LSB-first bit cells, stop bit, collision check.
module joybus_tx
  import joybus_tx_pkg::*;
#(
  parameter int CLKS_PER_US   = 49,
  parameter int IDLE_GUARD_US = 8,
  parameter int STOP_LOW_US   = 2,
  parameter int SETTLE_CLKS   = 8
) (
  input  logic        N64_CLK_i,
  input  logic        CTRL_nRST,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [2:0]  tx_len_i,
  input  logic [31:0] tx_data_i,
  input  logic        tx_abort_i,
  input  logic        CTRL_i,
  output logic        ctrl_oe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int GW = $clog2(IDLE_GUARD_US + 1);
  localparam int SW = $clog2(SETTLE_CLKS + 1);

  logic [2:0]    state, nxt;
  logic [31:0]   data_sr;
  logic [5:0]    nbits, bit_cnt;
  logic [1:0]    phase, low_last;
  logic [GW-1:0] guard_cnt;
  logic [SW-1:0] settle_cnt;
  logic          line_s, us_tick, restart, done_n, err_n, collide, shift_en;

  register_sync #(.WIDTH(1), .PRESET(1'b1)) u_sync (
    .clk (N64_CLK_i),
    .nrst(CTRL_nRST),
    .d   (CTRL_i),
    .q   (line_s)
  );

  joybus_us_tick #(.CLKS_PER_US(CLKS_PER_US)) u_tick (
    .clk    (N64_CLK_i),
    .nrst   (CTRL_nRST),
    .restart(restart),
    .us_tick(us_tick)
  );

  assign low_last = data_sr[0] ? 2'(BIT1_LOW_US - 1) : 2'(BIT0_LOW_US - 1);
  assign collide  = (state == ST_HIGH) && (settle_cnt == SW'(SETTLE_CLKS)) && !line_s;
  assign shift_en = (state == ST_HIGH) && !collide && !tx_abort_i && us_tick &&
                    (phase == 2'(BIT_CELL_US - 1));

  always_comb begin
    nxt    = state;
    done_n = 1'b0;
    err_n  = 1'b0;
    case (state)
      ST_IDLE:     if (tx_valid_i) nxt = ST_GUARD;
      ST_GUARD:    if (line_s && us_tick && guard_cnt == GW'(IDLE_GUARD_US - 1))
                     nxt = (nbits == 6'd0) ? ST_STOP_LOW : ST_LOW;
      ST_LOW:      if (us_tick && phase == low_last) nxt = ST_HIGH;
      ST_HIGH: begin
        if (collide) begin
          nxt   = ST_IDLE;
          err_n = 1'b1;
        end else if (shift_en) begin
          nxt = (bit_cnt + 6'd1 == nbits) ? ST_STOP_LOW : ST_LOW;
        end
      end
      ST_STOP_LOW: if (us_tick && phase == 2'(STOP_LOW_US - 1)) nxt = ST_STOP_REL;
      ST_STOP_REL: begin
        if (settle_cnt == SW'(SETTLE_CLKS - 1)) begin
          nxt    = ST_IDLE;
          done_n = line_s;
          err_n  = !line_s;
        end
      end
      default:     nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && tx_abort_i) begin
      nxt    = ST_IDLE;
      done_n = 1'b0;
      err_n  = 1'b1;
    end
    // a low line during guard counts as re-entering the guard, so the 8 us restart exactly on release
    restart = (nxt != state) || (state == ST_GUARD && !line_s);
  end

  always_ff @(posedge N64_CLK_i or negedge CTRL_nRST) begin
    if (!CTRL_nRST) begin
      state      <= ST_IDLE;
      data_sr    <= '0;
      nbits      <= '0;
      bit_cnt    <= '0;
      phase      <= '0;
      guard_cnt  <= '0;
      settle_cnt <= '0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state  <= nxt;
      done_o <= done_n;
      err_o  <= err_n;
      if (state == ST_IDLE && tx_valid_i) begin
        data_sr <= tx_data_i;
        nbits   <= frame_bits(tx_len_i);
        bit_cnt <= '0;
      end else if (shift_en) begin
        data_sr <= data_sr >> 1;
        bit_cnt <= bit_cnt + 6'd1;
      end
      // phase runs across LOW->HIGH so it always counts us within the bit cell
      if (nxt == ST_IDLE)
        phase <= '0;
      else if (us_tick && (state == ST_LOW || state == ST_HIGH || state == ST_STOP_LOW))
        phase <= phase + 2'd1;
      if (state == ST_GUARD && line_s) begin
        if (us_tick) guard_cnt <= guard_cnt + GW'(1);
      end else begin
        guard_cnt <= '0;
      end
      if (nxt != state)
        settle_cnt <= '0;
      else if ((state == ST_HIGH || state == ST_STOP_REL) && settle_cnt != SW'(SETTLE_CLKS))
        settle_cnt <= settle_cnt + SW'(1);
    end
  end

  assign ctrl_oe_o  = (state == ST_LOW || state == ST_STOP_LOW) && !tx_abort_i;
  assign tx_ready_o = (state == ST_IDLE);
  assign busy_o     = (state != ST_IDLE);

endmodule
